// File: rtl/regtest_pkg.sv
// Shared types and constants for the run-then-scan register test harness.
package regtest_pkg;

  // Harness sequencing states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_SCAN_ADDR = 3'd2,
    ST_SCAN_CMP  = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  // Value of the mode input sampled with start
  localparam logic MODE_DUMP    = 1'b0;
  localparam logic MODE_COMPARE = 1'b1;

endpackage

// File: rtl/regtest_scan_ctr.sv
// Register index counter for the scan phase.
// Ports: clock/reset, clear (return to index 0), advance (step to next
// index), idx (current register index), last_c (idx is the final register).
module regtest_scan_ctr #(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  advance,
  output logic [REG_ADDR_W-1:0] idx,
  output logic                  last_c
);

  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

  // Index register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (advance) begin
      idx <= idx + REG_ADDR_W'(1);
    end
  end

  assign last_c = (idx == LAST_IDX);

endmodule

// File: rtl/regtest_harness.sv
// Run-then-scan harness: runs the core for num_cycles, then walks regfile
// read port A over every register, streaming values and (in compare mode)
// checking them against a registered expected-value ROM.
// Ports: clock/reset/start/mode/num_cycles control; run_active gates the
// core; test_mode/test_reg steer read-A; reg_data is read-A data;
// exp_addr/exp_data talk to the ROM (1-cycle latency); dump_* strobe one
// register per scan step; cycle_count/error_count/first_fail_*/done/pass
// report results.
module regtest_harness
  import regtest_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CYCLE_W    = 16,
  parameter int unsigned ERR_W      = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [CYCLE_W-1:0]    num_cycles,
  output logic                  run_active,
  output logic                  test_mode,
  output logic [REG_ADDR_W-1:0] test_reg,
  input  logic [DATA_WIDTH-1:0] reg_data,
  output logic [REG_ADDR_W-1:0] exp_addr,
  input  logic [DATA_WIDTH-1:0] exp_data,
  output logic                  dump_valid,
  output logic [REG_ADDR_W-1:0] dump_reg,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_mismatch,
  output logic [CYCLE_W-1:0]    cycle_count,
  output logic [ERR_W-1:0]      error_count,
  output logic                  first_fail_valid,
  output logic [REG_ADDR_W-1:0] first_fail_reg,
  output logic                  done,
  output logic                  pass
);

  state_t                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [CYCLE_W-1:0]    num_q, num_d;
  logic [CYCLE_W-1:0]    cycle_count_d;
  logic [ERR_W-1:0]      error_count_d;
  logic                  first_fail_valid_d;
  logic [REG_ADDR_W-1:0] first_fail_reg_d;
  logic                  dump_valid_d, dump_mismatch_d;
  logic [REG_ADDR_W-1:0] dump_reg_d;
  logic [DATA_WIDTH-1:0] dump_data_d;
  logic                  run_active_d, test_mode_d, done_d, pass_d;
  logic                  ctr_clear_c, ctr_advance_c, ctr_last_c, mismatch_c;

  regtest_scan_ctr #(
    .NUM_REGS   (NUM_REGS),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_scan_ctr (
    .clock   (clock),
    .reset   (reset),
    .clear   (ctr_clear_c),
    .advance (ctr_advance_c),
    .idx     (test_reg),
    .last_c  (ctr_last_c)
  );

  // ROM is addressed by the same index as the regfile
  assign exp_addr = test_reg;

  // Dump mode never flags a mismatch
  assign mismatch_c = (mode_q != MODE_DUMP) && (reg_data != exp_data);

  // Next-state and next-output logic
  always_comb begin
    state_d            = state_q;
    mode_d             = mode_q;
    num_d              = num_q;
    cycle_count_d      = cycle_count;
    error_count_d      = error_count;
    first_fail_valid_d = first_fail_valid;
    first_fail_reg_d   = first_fail_reg;
    dump_valid_d       = 1'b0;
    dump_mismatch_d    = 1'b0;
    dump_reg_d         = dump_reg;
    dump_data_d        = dump_data;
    ctr_clear_c        = 1'b0;
    ctr_advance_c      = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mode_d             = mode;
          num_d              = num_cycles;
          cycle_count_d      = '0;
          error_count_d      = '0;
          first_fail_valid_d = 1'b0;
          first_fail_reg_d   = '0;
          ctr_clear_c        = 1'b1;
          state_d            = (num_cycles != '0) ? ST_RUN : ST_SCAN_ADDR;
        end
      end
      ST_RUN: begin
        cycle_count_d = cycle_count + CYCLE_W'(1);
        if (cycle_count == num_q - CYCLE_W'(1)) begin
          state_d = ST_SCAN_ADDR;
        end
      end
      ST_SCAN_ADDR: begin
        state_d = ST_SCAN_CMP;
      end
      ST_SCAN_CMP: begin
        dump_valid_d    = 1'b1;
        dump_reg_d      = test_reg;
        dump_data_d     = reg_data;
        dump_mismatch_d = mismatch_c;
        if (mismatch_c) begin
          error_count_d = error_count + ERR_W'(1);
          // Ascending scan order makes the first hit the lowest index
          if (!first_fail_valid) begin
            first_fail_valid_d = 1'b1;
            first_fail_reg_d   = test_reg;
          end
        end
        if (ctr_last_c) begin
          state_d = ST_DONE;
        end else begin
          ctr_advance_c = 1'b1;
          state_d       = ST_SCAN_ADDR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    run_active_d = (state_d == ST_RUN);
    test_mode_d  = (state_d == ST_SCAN_ADDR) || (state_d == ST_SCAN_CMP);
    done_d       = (state_d == ST_DONE);
    pass_d       = done_d && (mode_d == MODE_COMPARE) && (error_count_d == '0);
  end

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      mode_q           <= 1'b0;
      num_q            <= '0;
      cycle_count      <= '0;
      error_count      <= '0;
      first_fail_valid <= 1'b0;
      first_fail_reg   <= '0;
      dump_valid       <= 1'b0;
      dump_mismatch    <= 1'b0;
      dump_reg         <= '0;
      dump_data        <= '0;
      run_active       <= 1'b0;
      test_mode        <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
    end else begin
      state_q          <= state_d;
      mode_q           <= mode_d;
      num_q            <= num_d;
      cycle_count      <= cycle_count_d;
      error_count      <= error_count_d;
      first_fail_valid <= first_fail_valid_d;
      first_fail_reg   <= first_fail_reg_d;
      dump_valid       <= dump_valid_d;
      dump_mismatch    <= dump_mismatch_d;
      dump_reg         <= dump_reg_d;
      dump_data        <= dump_data_d;
      run_active       <= run_active_d;
      test_mode        <= test_mode_d;
      done             <= done_d;
      pass             <= pass_d;
    end
  end

endmodule

// File: tb/tb_regtest_harness.sv
// Self-checking bench for regtest_harness: behavioural regfile and ROM,
// expected results computed from the register/ROM contents per run.
module tb_regtest_harness;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 16;
  localparam int unsigned EW = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          mode;
  logic [CW-1:0] num_cycles;
  logic          run_active, test_mode;
  logic [AW-1:0] test_reg, exp_addr, dump_reg, first_fail_reg;
  logic [DW-1:0] reg_data, exp_data, dump_data;
  logic          dump_valid, dump_mismatch, first_fail_valid, done, pass;
  logic [CW-1:0] cycle_count;
  logic [EW-1:0] error_count;

  logic [DW-1:0] reg_mem [NR];
  logic [DW-1:0] rom_mem [NR];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  regtest_harness #(
    .DATA_WIDTH (DW), .NUM_REGS (NR), .REG_ADDR_W (AW),
    .CYCLE_W (CW), .ERR_W (EW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .mode             (mode),
    .num_cycles       (num_cycles),
    .run_active       (run_active),
    .test_mode        (test_mode),
    .test_reg         (test_reg),
    .reg_data         (reg_data),
    .exp_addr         (exp_addr),
    .exp_data         (exp_data),
    .dump_valid       (dump_valid),
    .dump_reg         (dump_reg),
    .dump_data        (dump_data),
    .dump_mismatch    (dump_mismatch),
    .cycle_count      (cycle_count),
    .error_count      (error_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_reg   (first_fail_reg),
    .done             (done),
    .pass             (pass)
  );

  // Combinational regfile read port and registered expected ROM
  assign reg_data = reg_mem[test_reg];
  always_ff @(posedge clock) exp_data <= rom_mem[exp_addr];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, 64'({run_active, test_mode, test_reg, exp_addr, dump_valid,
                                 dump_reg, dump_mismatch, first_fail_valid,
                                 first_fail_reg, done, pass}), 64'd0);
    check_eq({tag, "_cnt"}, 64'({cycle_count, error_count}), 64'd0);
    check_eq({tag, "_data"}, 64'(dump_data), 64'd0);
  endtask

  // One full run from IDLE/DONE; poke pulses a stray start during RUN
  task automatic do_run(input bit m, input int n, input bit poke);
    int  exp_err, exp_ff, ra_cnt, k, c;
    bit  exp_ffv, seen_done, exp_mm;
    exp_err = 0; exp_ff = 0; exp_ffv = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (m && reg_mem[i] != rom_mem[i]) begin
        exp_err++;
        if (!exp_ffv) begin exp_ffv = 1'b1; exp_ff = i; end
      end
    end
    @(negedge clock);
    start = 1'b1; mode = m; num_cycles = CW'(n);
    @(negedge clock);
    start = 1'b0;
    check_eq("run_first", 64'(run_active), 64'(n != 0));
    check_eq("cc_cleared", 64'(cycle_count), 64'd0);
    check_eq("err_cleared", 64'({error_count, first_fail_valid, done, pass}), 64'd0);
    ra_cnt = 0; k = 0; c = 1; seen_done = 1'b0;
    while (!seen_done && c < n + 4 * int'(NR) + 20) begin
      if (run_active) ra_cnt++;
      if (dump_valid) begin
        exp_mm = (k < int'(NR)) ? (m && reg_mem[k] != rom_mem[k]) : 1'b0;
        check_eq("dump_reg", 64'(dump_reg), 64'(k));
        check_eq("dump_data", 64'(dump_data), (k < int'(NR)) ? 64'(reg_mem[k]) : 64'd0);
        check_eq("dump_mm", 64'(dump_mismatch), 64'(exp_mm));
        k++;
      end
      if (done) begin
        seen_done = 1'b1;
      end else begin
        if (poke && c == 3) begin
          start = 1'b1; mode = ~m; num_cycles = CW'(n + 7);
        end else begin
          start = 1'b0;
        end
        @(negedge clock);
        c++;
      end
    end
    start = 1'b0;
    check_eq("done_seen", 64'(seen_done), 64'd1);
    check_eq("latency", 64'(c), 64'(1 + n + 2 * int'(NR)));
    check_eq("run_cycles", 64'(ra_cnt), 64'(n));
    check_eq("num_dumps", 64'(k), 64'(NR));
    check_eq("cycle_count", 64'(cycle_count), 64'(n));
    check_eq("error_count", 64'(error_count), 64'(exp_err));
    check_eq("ff_valid", 64'(first_fail_valid), 64'(exp_ffv));
    check_eq("ff_reg", 64'(first_fail_reg), 64'(exp_ff));
    check_eq("pass", 64'(pass), 64'(m && exp_err == 0));
    check_eq("idle_ctl", 64'({test_mode, run_active}), 64'd0);
    repeat (3) @(negedge clock);
    check_eq("hold", 64'({done, error_count}), 64'({1'b1, EW'(exp_err)}));
  endtask

  task automatic fill_identity();
    for (int i = 0; i < NR; i++) begin
      reg_mem[i] = DW'(i);
      rom_mem[i] = DW'(i);
    end
  endtask

  initial begin
    int budget;
    reset = 1'b1; start = 1'b0; mode = 1'b0; num_cycles = '0;
    fill_identity();
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("idle");

    // Matching data, compare mode, stray start mid-RUN
    do_run(1'b1, 10, 1'b1);

    // Two mismatches, restarted from DONE
    rom_mem[5] = 32'd99; rom_mem[17] = 32'd0;
    do_run(1'b1, 10, 1'b0);

    // Dump mode, zero run window, every register differs
    for (int i = 0; i < NR; i++) rom_mem[i] = ~reg_mem[i];
    do_run(1'b0, 0, 1'b0);

    // Compare mode, everything mismatching
    do_run(1'b1, 1, 1'b0);

    // Reset in the middle of the scan
    fill_identity();
    @(negedge clock);
    start = 1'b1; mode = 1'b1; num_cycles = CW'(4);
    @(negedge clock);
    start = 1'b0;
    budget = 0;
    while (!(test_mode && test_reg == AW'(12)) && budget < 200) begin
      @(negedge clock);
      budget++;
    end
    check_eq("reach_k12", 64'(budget < 200), 64'd1);
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clock); #1;
    check_all_zero("rst_hold");
    @(negedge clock);
    reset = 1'b0;
    do_run(1'b1, 3, 1'b0);

    // Randomized contents, mode and run length
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NR; i++) begin
        reg_mem[i] = $urandom;
        rom_mem[i] = reg_mem[i];
        if ($urandom_range(0, 3) == 0) rom_mem[i] = reg_mem[i] ^ (32'h1 << $urandom_range(0, 31));
      end
      do_run(1'($urandom_range(0, 1)), int'($urandom_range(0, 20)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regtest_harness.md
# regtest_harness

Synthesizable run-then-scan harness for the single-cycle processor. It holds the core in a run window for a programmable number of cycles, then takes over regfile read port A to scan every architectural register. In compare mode it checks each register against an expected-value memory and reports error count and first failure; in dump mode it only streams register contents. It sits between the processor, the regfile read-A mux and an expected-value ROM, enabling on-board self-check without a simulator.

## Interface
- DATA_WIDTH, 32, register/expected data width
- NUM_REGS, 32, registers scanned (0..NUM_REGS-1)
- REG_ADDR_W, 5, register index width; must satisfy 2^REG_ADDR_W >= NUM_REGS
- CYCLE_W, 16, width of run-cycle counter
- ERR_W, 6, error counter width; must satisfy 2^ERR_W > NUM_REGS

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE
- mode  in  1  0 = dump only, 1 = compare; sampled with start
- num_cycles  in  CYCLE_W  run-window length; sampled with start
- run_active  out  1  high while processor may execute (RUN state)
- test_mode  out  1  select for regfile read-A mux (high in SCAN_ADDR/SCAN_CMP)
- test_reg  out  REG_ADDR_W  register index driven to read-A mux
- reg_data  in  DATA_WIDTH  regfile read-A data, combinational from test_reg
- exp_addr  out  REG_ADDR_W  expected-ROM address (equals test_reg)
- exp_data  in  DATA_WIDTH  expected-ROM data, registered, 1-cycle latency
- dump_valid  out  1  one-cycle strobe per scanned register
- dump_reg  out  REG_ADDR_W  index of the strobed register
- dump_data  out  DATA_WIDTH  value of the strobed register
- dump_mismatch  out  1  strobed register mismatched (compare mode only, else 0)
- cycle_count  out  CYCLE_W  cycles elapsed in RUN
- error_count  out  ERR_W  mismatches in this scan
- first_fail_valid  out  1  at least one mismatch seen
- first_fail_reg  out  REG_ADDR_W  lowest failing register index
- done  out  1  high in DONE
- pass  out  1  high in DONE when mode=1 and error_count=0; 0 in dump mode

## Operation
- States: IDLE, RUN, SCAN_ADDR, SCAN_CMP, DONE.
- IDLE/DONE + start: latch mode and num_cycles, clear cycle_count, error_count, first_fail_*, test_reg=0; go to RUN when num_cycles!=0, else straight to SCAN_ADDR.
- RUN: run_active=1, cycle_count increments each cycle; when cycle_count==num_cycles-1 go to SCAN_ADDR (exactly num_cycles RUN cycles).
- SCAN_ADDR: test_mode=1, drive test_reg/exp_addr=k; go to SCAN_CMP.
- SCAN_CMP: test_mode=1, test_reg held at k; sample reg_data and exp_data; pulse dump_valid with dump_reg=k, dump_data=reg_data; in compare mode, mismatch (any bit differs) increments error_count and, if first_fail_valid=0, sets first_fail_reg=k. If k==NUM_REGS-1 go to DONE, else k+1 and SCAN_ADDR.
- DONE: hold all results; test_mode=0, run_active=0.
- start outside IDLE/DONE ignored. start in DONE restarts a full run.
- Register 0 is scanned and compared like any other.

## Timing
- Reset values: state IDLE; every output 0.
- start to run_active: 1 cycle.
- Scan takes exactly 2*NUM_REGS cycles; done rises the cycle after the last SCAN_CMP.
- Total start-to-done latency: 1 + num_cycles + 2*NUM_REGS cycles.
- dump_* and dump_mismatch registered: asserted in cycle after SCAN_CMP, one cycle wide; results counters update same edge.
- Reset asserted mid-RUN or mid-scan: immediate return to IDLE with all outputs 0, no partial results retained.

## Structure
- Package regtest_pkg: state enum encoding, MODE_DUMP/MODE_COMPARE constants.
- Sub-module regtest_scan_ctr: register index counter with terminal flag (k==NUM_REGS-1); everything else in the top FSM.

## Test plan
- num_cycles=10, mode=1, reg model returns r[k]=k, ROM exp[k]=k -> run_active high 10 cycles, done at 1+10+64=75 cycles after start, pass=1, error_count=0.
- Same but exp[5]=99 and exp[17]=0 -> error_count=2, first_fail_reg=5, dump_mismatch strobed for k=5 and 17 only, pass=0.
- num_cycles=0, mode=0, all registers mismatching -> no RUN cycles, 32 dump strobes with dump_data=r[k], error_count=0, pass=0.
- reset pulsed during SCAN at k=12 -> all outputs 0 next cycle; new start with matching data completes with pass=1.
- start pulsed during RUN -> ignored, cycle_count unaffected; start in DONE -> counters cleared, second run completes identically.
- Parameter set NUM_REGS=8, REG_ADDR_W=3, ERR_W=4, all mismatching -> error_count=8, first_fail_reg=0, scan 16 cycles.
